mjolnir_arb: RTL and testbench

Round-robin arbiter and issue sequencer that shares one `mjolnir` K-bit adder between N requesters. Each requester offers an operand pair over a valid/ready handshake. The block grants one requester per cycle, registers the winning operands onto the adder inputs, tracks in-flight operations with a tag pipeline matched to the adder latency, and returns each sum and carry to the originating requester. It sits between the requester ports and the `mjolnir` instance in the datapath.

---
 rtl/mjolnir_arb.sv | 117 +++++++++++
 tb/tb_mjolnir_arb.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mjolnir_arb.sv
`default_nettype none
// ============================================================================
// Module   : mjolnir_arb
// Purpose  : Round-robin arbiter and issue sequencer sharing one K-bit adder
//            between N requesters. Grants one requester per cycle, registers
//            its operands onto the adder inputs, tracks in-flight operations
//            with a tag pipeline matched to the adder latency, and routes each
//            sum/carry back to the requester that issued it.
// Ports    : clk        - rising-edge clock
//            rst_n      - asynchronous active-low reset
//            req_valid  - per-requester request valid            [N]
//            req_ready  - per-requester accept, one-hot or zero  [N]
//            req_a/b    - packed operands, requester i at [i*K +: K]
//            add_a/b    - registered operands to the adder       [K]
//            add_s      - adder sum                              [K]
//            add_cout   - adder carry-out
//            rsp_valid  - one-hot response strobe                [N]
//            rsp_s      - sum for the strobed requester          [K]
//            rsp_cout   - carry for the strobed requester
//            busy       - any operation in flight
// Revision : 1.0 - initial release
// ============================================================================
module mjolnir_arb #(
  parameter int K   = 64,
  parameter int N   = 4,
  parameter int LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*K-1:0] req_a,
  input  logic [N*K-1:0] req_b,
  output logic [K-1:0]   add_a,
  output logic [K-1:0]   add_b,
  input  logic [K-1:0]   add_s,
  input  logic           add_cout,
  output logic [N-1:0]   rsp_valid,
  output logic [K-1:0]   rsp_s,
  output logic           rsp_cout,
  output logic           busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [K-1:0]  r_add_a;
  logic [K-1:0]  r_add_b;
  logic [LAT:0]  r_tv;             // tag valid per stage, stage LAT is the tail
  logic [PW-1:0] r_ti [LAT+1];     // tag requester index per stage

  logic          w_found;
  logic [PW-1:0] w_gnt_idx;
  logic [PW:0]   w_cand;
  logic [PW-1:0] w_ptr_nxt;

  // Scan N candidates starting at the pointer; the candidate index is reduced
  // modulo N with a single conditional subtract since ptr < N and offset < N.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int off = 0; off < N; off++) begin
      w_cand = {1'b0, r_ptr} + (PW+1)'(off);
      if (w_cand >= (PW+1)'(N)) begin
        w_cand = w_cand - (PW+1)'(N);
      end
      if (!w_found && req_valid[w_cand[PW-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand[PW-1:0];
      end
    end
  end

  // A grant is only ever given to a valid requester, so w_found is the transfer.
  assign req_ready = w_found ? (N'(1) << w_gnt_idx) : '0;
  assign w_ptr_nxt = (w_gnt_idx == PW'(N - 1)) ? '0 : w_gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_add_a <= '0;
      r_add_b <= '0;
    end else if (w_found) begin
      r_ptr   <= w_ptr_nxt;
      r_add_a <= req_a[w_gnt_idx*K +: K];
      r_add_b <= req_b[w_gnt_idx*K +: K];
    end
  end

  // Tag pipeline: no stall, every stage advances each cycle so the tail lines
  // up exactly with the adder result for the operands issued LAT+1 cycles ago.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tv <= '0;
      for (int s = 0; s <= LAT; s++) begin
        r_ti[s] <= '0;
      end
    end else begin
      r_tv[0] <= w_found;
      r_ti[0] <= w_gnt_idx;
      for (int s = 1; s <= LAT; s++) begin
        r_tv[s] <= r_tv[s-1];
        r_ti[s] <= r_ti[s-1];
      end
    end
  end

  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign rsp_valid = r_tv[LAT] ? (N'(1) << r_ti[LAT]) : '0;
  assign rsp_s     = add_s;
  assign rsp_cout  = add_cout;
  assign busy      = |r_tv;

endmodule
`default_nettype wire

// File: tb/tb_mjolnir_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mjolnir_arb
// Purpose  : Self-checking bench for mjolnir_arb. Two instances (LAT=1 and
//            LAT=3) share stimulus; each is paired with a behavioural adder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mjolnir_arb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   vld;
  logic [255:0] ra, rb;

  logic [3:0]  rdy1, rdy3, rv1, rv3;
  logic [63:0] aa1, ab1, aa3, ab3, as1, as3, rs1, rs3;
  logic        ac1, ac3, rc1, rc3, bz1, bz3;

  always #5 clk = ~clk;

  mjolnir_arb #(.K(64), .N(4), .LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(vld), .req_ready(rdy1),
    .req_a(ra), .req_b(rb), .add_a(aa1), .add_b(ab1),
    .add_s(as1), .add_cout(ac1), .rsp_valid(rv1), .rsp_s(rs1),
    .rsp_cout(rc1), .busy(bz1));

  mjolnir_arb #(.K(64), .N(4), .LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(vld), .req_ready(rdy3),
    .req_a(ra), .req_b(rb), .add_a(aa3), .add_b(ab3),
    .add_s(as3), .add_cout(ac3), .rsp_valid(rv3), .rsp_s(rs3),
    .rsp_cout(rc3), .busy(bz3));

  // Behavioural adders with 1 and 3 cycles of latency.
  logic [64:0] p1;
  logic [64:0] p3 [3];
  always @(posedge clk) begin
    p1    <= {1'b0, aa1} + {1'b0, ab1};
    p3[0] <= {1'b0, aa3} + {1'b0, ab3};
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign as1 = p1[63:0];
  assign ac1 = p1[64];
  assign as3 = p3[2][63:0];
  assign ac3 = p3[2][64];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    int          idx;
    logic [64:0] sum;
  } ent_t;

  ent_t        q1[$];
  ent_t        q3[$];
  int          cyc;
  int          m_ptr;
  int          m_grant;
  logic [63:0] m_adda, m_addb;

  task automatic model_reset();
    q1.delete();
    q3.delete();
    m_ptr  = 0;
    m_adda = '0;
    m_addb = '0;
  endtask

  task automatic chk_rsp(input string t, input bit has, input ent_t e,
                         input logic [3:0] rv, input logic [63:0] s,
                         input logic c, input logic bz, input bit ebz);
    logic [3:0] erv;
    erv = has ? 4'(1 << e.idx) : 4'd0;
    chk({t, "_rsp_valid"}, 65'(rv), 65'(erv));
    if (has) begin
      chk({t, "_rsp_s"}, 65'(s), 65'(e.sum[63:0]));
      chk({t, "_rsp_cout"}, 65'(c), 65'(e.sum[64]));
    end
    chk({t, "_busy"}, 65'(bz), 65'(ebz));
  endtask

  task automatic model_check();
    logic [3:0] erdy;
    ent_t       e;
    bit         h;
    m_grant = -1;
    for (int o = 0; o < 4; o++) begin
      if (m_grant < 0 && vld[(m_ptr + o) % 4]) m_grant = (m_ptr + o) % 4;
    end
    erdy = (m_grant < 0) ? 4'd0 : 4'(1 << m_grant);
    chk("m_ready1", 65'(rdy1), 65'(erdy));
    chk("m_ready3", 65'(rdy3), 65'(erdy));
    chk("m_add_a1", 65'(aa1), 65'(m_adda));
    chk("m_add_b1", 65'(ab1), 65'(m_addb));
    chk("m_add_a3", 65'(aa3), 65'(m_adda));
    chk("m_add_b3", 65'(ab3), 65'(m_addb));
    e = '{0, 0, 65'd0};
    h = (q1.size() > 0) && (q1[0].due == cyc);
    if (h) e = q1[0];
    chk_rsp("m1", h, e, rv1, rs1, rc1, bz1, q1.size() > 0);
    e = '{0, 0, 65'd0};
    h = (q3.size() > 0) && (q3[0].due == cyc);
    if (h) e = q3[0];
    chk_rsp("m3", h, e, rv3, rs3, rc3, bz3, q3.size() > 0);
  endtask

  task automatic model_adv();
    logic [64:0] sum;
    if (q1.size() > 0 && q1[0].due == cyc) void'(q1.pop_front());
    if (q3.size() > 0 && q3[0].due == cyc) void'(q3.pop_front());
    if (m_grant >= 0) begin
      m_adda = ra[m_grant*64 +: 64];
      m_addb = rb[m_grant*64 +: 64];
      sum    = {1'b0, m_adda} + {1'b0, m_addb};
      q1.push_back('{cyc + 2, m_grant, sum});
      q3.push_back('{cyc + 4, m_grant, sum});
      m_ptr  = (m_grant + 1) % 4;
    end
    cyc++;
  endtask

  task automatic half_check();
    @(negedge clk);
    model_check();
  endtask

  task automatic half_adv();
    @(posedge clk);
    model_adv();
    #1;
  endtask

  task automatic step();
    half_check();
    half_adv();
  endtask

  // Step, then withdraw whichever request the model says was accepted.
  task automatic step_drop();
    step();
    if (m_grant >= 0) vld[m_grant] = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && vld != 4'd0; k++) step_drop();
  endtask

  function automatic logic [255:0] pk(input logic [63:0] x3, x2, x1, x0);
    return {x3, x2, x1, x0};
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0]   vld;
    logic [255:0] a, b;
    logic [3:0]   rdy, rsp;
    logic [63:0]  s;
    logic         c, bz;
  } row_t;

  function automatic row_t mk(input logic [3:0] v, input logic [255:0] a, b,
                              input logic [3:0] rdy, rsp, input logic [63:0] s,
                              input logic c, bz);
    row_t r;
    r.vld = v; r.a = a; r.b = b; r.rdy = rdy; r.rsp = rsp; r.s = s; r.c = c; r.bz = bz;
    return r;
  endfunction

  row_t tbl [25];

  initial begin
    logic [255:0] a0, b0, ac, bc, af, bf, ap, bp, z;
    logic [63:0]  ones;
    ones = '1;
    z  = '0;
    a0 = pk(0, 0, 0, 1);     b0 = pk(0, 0, 0, 1);
    ac = pk(0, ones, 0, 0);  bc = pk(0, 1, 0, 0);
    af = pk(3, 2, 1, 0);     bf = pk(30, 20, 10, 0);
    ap = pk(9, 100, 7, 0);   bp = pk(9, 1, 8, 0);
    //              vld  a   b   rdy  rsp  s    c  busy
    tbl[0]  = mk(4'h1, a0, b0, 4'h1, 4'h0, 0,   0, 0);
    tbl[1]  = mk(4'h0, a0, b0, 4'h0, 4'h0, 0,   0, 1);
    tbl[2]  = mk(4'h0, a0, b0, 4'h0, 4'h1, 2,   0, 1);
    tbl[3]  = mk(4'h4, ac, bc, 4'h4, 4'h0, 0,   0, 0);
    tbl[4]  = mk(4'h0, ac, bc, 4'h0, 4'h0, 0,   0, 1);
    tbl[5]  = mk(4'h0, ac, bc, 4'h0, 4'h4, 0,   1, 1);
    tbl[6]  = mk(4'h8, z,  z,  4'h8, 4'h0, 0,   0, 0);
    tbl[7]  = mk(4'hF, af, bf, 4'h1, 4'h0, 0,   0, 1);
    tbl[8]  = mk(4'hF, af, bf, 4'h2, 4'h8, 0,   0, 1);
    tbl[9]  = mk(4'hF, af, bf, 4'h4, 4'h1, 0,   0, 1);
    tbl[10] = mk(4'hF, af, bf, 4'h8, 4'h2, 11,  0, 1);
    tbl[11] = mk(4'hF, af, bf, 4'h1, 4'h4, 22,  0, 1);
    tbl[12] = mk(4'hF, af, bf, 4'h2, 4'h8, 33,  0, 1);
    tbl[13] = mk(4'hD, af, bf, 4'h4, 4'h1, 0,   0, 1);
    tbl[14] = mk(4'h9, af, bf, 4'h8, 4'h2, 11,  0, 1);
    tbl[15] = mk(4'h1, af, bf, 4'h1, 4'h4, 22,  0, 1);
    tbl[16] = mk(4'h0, af, bf, 4'h0, 4'h8, 33,  0, 1);
    tbl[17] = mk(4'h0, af, bf, 4'h0, 4'h1, 0,   0, 1);
    tbl[18] = mk(4'h0, af, bf, 4'h0, 4'h0, 0,   0, 0);
    tbl[19] = mk(4'h4, ap, bp, 4'h4, 4'h0, 0,   0, 0);
    tbl[20] = mk(4'hA, ap, bp, 4'h8, 4'h0, 0,   0, 1);
    tbl[21] = mk(4'h2, ap, bp, 4'h2, 4'h4, 101, 0, 1);
    tbl[22] = mk(4'h0, ap, bp, 4'h0, 4'h8, 18,  0, 1);
    tbl[23] = mk(4'h0, ap, bp, 4'h0, 4'h2, 15,  0, 1);
    tbl[24] = mk(4'h0, ap, bp, 4'h0, 4'h0, 0,   0, 0);

    // ---- reset state ----
    rst_n = 1'b0; vld = '0; ra = '0; rb = '0;
    cyc = 0; m_grant = -1;
    model_reset();
    #3;
    chk("rst_rsp_valid", 65'(rv1), 65'd0);
    chk("rst_busy", 65'(bz1), 65'd0);
    chk("rst_add_a", 65'(aa1), 65'd0);
    chk("rst_add_b", 65'(ab1), 65'd0);
    chk("rst_ready_idle", 65'(rdy1), 65'd0);
    vld = 4'b1010;
    #1;
    chk("rst_ready_ptr0", 65'(rdy1), 65'(4'b0010));
    vld = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // ---- directed table ----
    for (int i = 0; i < 25; i++) begin
      vld = tbl[i].vld; ra = tbl[i].a; rb = tbl[i].b;
      half_check();
      chk($sformatf("tbl%0d_ready", i), 65'(rdy1), 65'(tbl[i].rdy));
      chk($sformatf("tbl%0d_rsp_valid", i), 65'(rv1), 65'(tbl[i].rsp));
      if (tbl[i].rsp != 4'd0) begin
        chk($sformatf("tbl%0d_rsp_s", i), 65'(rs1), 65'(tbl[i].s));
        chk($sformatf("tbl%0d_rsp_cout", i), 65'(rc1), 65'(tbl[i].c));
      end
      chk($sformatf("tbl%0d_busy", i), 65'(bz1), 65'(tbl[i].bz));
      half_adv();
    end

    // ---- randomized traffic against the model ----
    vld = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!vld[i] && $urandom_range(0, 1) == 1) begin
          vld[i] = 1'b1;
          if ($urandom_range(0, 3) == 0) ra[i*64 +: 64] = '1;
          else ra[i*64 +: 64] = {$urandom, $urandom};
          rb[i*64 +: 64] = ($urandom_range(0, 3) == 0) ? 64'd1 : {$urandom, $urandom};
        end
      end
      step_drop();
    end
    drain();
    for (int k = 0; k < 5; k++) step();

    // ---- reset mid-flight ----
    vld = 4'b0010; ra = pk(0, 0, 5, 0); rb = pk(0, 0, 7, 0);
    step();
    vld = '0;
    rst_n = 1'b0;
    #2;
    chk("mid_busy1", 65'(bz1), 65'd0);
    chk("mid_rsp1", 65'(rv1), 65'd0);
    chk("mid_busy3", 65'(bz3), 65'd0);
    chk("mid_rsp3", 65'(rv3), 65'd0);
    #1 rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      half_check();
      chk("mid_no_rsp", 65'(rv1 | rv3), 65'd0);
      half_adv();
    end
    vld = 4'b1111; ra = pk(3, 2, 1, 0); rb = pk(30, 20, 10, 0);
    half_check();
    chk("mid_ptr0_grant", 65'(rdy1), 65'(4'b0001));
    half_adv();
    vld[0] = 1'b0;
    drain();
    for (int k = 0; k < 5; k++) step();

    // ---- LAT=3 exact latency ----
    vld = 4'b0001; ra = pk(0, 0, 0, 3); rb = pk(0, 0, 0, 4);
    step();
    vld = '0;
    for (int k = 1; k <= 5; k++) begin
      half_check();
      chk($sformatf("lat3_rsp_valid_c%0d", k), 65'(rv3), (k == 4) ? 65'd1 : 65'd0);
      if (k == 4) chk("lat3_rsp_s", 65'(rs3), 65'd7);
      half_adv();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
